// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multicycle MIPS controller: opcodes, ALU-control
// codes, datapath mux selects, FSM states and the control bundle.
package mips_ctrl_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  // ALUOp codes, also decoded by the ALU-control block; 2'b11 is never driven.
  typedef enum logic [1:0] {
    ALUOP_ADD   = 2'b00,
    ALUOP_SUB   = 2'b01,
    ALUOP_FUNCT = 2'b10
  } aluop_e;

  typedef enum logic [1:0] {
    SRCB_REGB    = 2'b00,
    SRCB_FOUR    = 2'b01,
    SRCB_IMM     = 2'b10,
    SRCB_IMM_SH2 = 2'b11
  } alusrcb_e;

  typedef enum logic [1:0] {
    PCSRC_ALURESULT = 2'b00,
    PCSRC_ALUOUT    = 2'b01,
    PCSRC_JUMP      = 2'b10
  } pcsrc_e;

  // Codes 12-15 are left unused and only reachable through a state upset.
  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECUTE  = 4'd6,
    S_ALUWB    = 4'd7,
    S_BRANCH   = 4'd8,
    S_ADDIEXEC = 4'd9,
    S_ADDIWB   = 4'd10,
    S_JUMP     = 4'd11
  } state_e;

  typedef struct packed {
    logic     iord;
    logic     mem_write;
    logic     ir_write;
    logic     reg_dst;
    logic     mem_to_reg;
    logic     reg_write;
    logic     alu_src_a;
    alusrcb_e alu_src_b;
    aluop_e   alu_op;
    pcsrc_e   pc_src;
    logic     pc_write;
    logic     branch;
  } ctrl_t;

  function automatic logic is_supported_op(input logic [5:0] op);
    return (op == OP_RTYPE) || (op == OP_LW) || (op == OP_SW) ||
           (op == OP_BEQ) || (op == OP_ADDI) || (op == OP_J);
  endfunction

endpackage

// File: rtl/mips_ctrl_outdec.sv
// Moore output decoder: maps the current FSM state to the control bundle.
module mips_ctrl_outdec
  import mips_ctrl_pkg::*;
(
  input  state_e state,
  output ctrl_t  ctrl
);

  // Every control defaults to 0; each state raises only what it needs.
  always_comb begin
    ctrl = '0;
    case (state)
      S_FETCH: begin
        ctrl.alu_src_b = SRCB_FOUR;
        ctrl.alu_op    = ALUOP_ADD;
        ctrl.ir_write  = 1'b1;
        ctrl.pc_write  = 1'b1;
      end
      S_DECODE: begin
        ctrl.alu_src_b = SRCB_IMM_SH2;
        ctrl.alu_op    = ALUOP_ADD;
      end
      S_MEMADR: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_IMM;
        ctrl.alu_op    = ALUOP_ADD;
      end
      S_MEMREAD: begin
        ctrl.iord = 1'b1;
      end
      S_MEMWB: begin
        ctrl.mem_to_reg = 1'b1;
        ctrl.reg_write  = 1'b1;
      end
      S_MEMWRITE: begin
        ctrl.iord      = 1'b1;
        ctrl.mem_write = 1'b1;
      end
      S_EXECUTE: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_REGB;
        ctrl.alu_op    = ALUOP_FUNCT;
      end
      S_ALUWB: begin
        ctrl.reg_dst   = 1'b1;
        ctrl.reg_write = 1'b1;
      end
      S_BRANCH: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_REGB;
        ctrl.alu_op    = ALUOP_SUB;
        ctrl.pc_src    = PCSRC_ALUOUT;
        ctrl.branch    = 1'b1;
      end
      S_ADDIEXEC: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_IMM;
        ctrl.alu_op    = ALUOP_ADD;
      end
      S_ADDIWB: begin
        ctrl.reg_write = 1'b1;
      end
      S_JUMP: begin
        ctrl.pc_src   = PCSRC_JUMP;
        ctrl.pc_write = 1'b1;
      end
      default: ctrl = '0;
    endcase
  end

endmodule

// File: rtl/mips_multicycle_ctrl.sv
// Multicycle MIPS main controller: state register, next-state logic and the
// reset gating of the write strobes around the Moore output decoder.
module mips_multicycle_ctrl
  import mips_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] Op,
  input  logic       Zero,
  output logic       IorD,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       RegDst,
  output logic       MemtoReg,
  output logic       RegWrite,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ALUOp,
  output logic [1:0] PCSrc,
  output logic       PCEn,
  output logic       IllegalOp,
  output logic [3:0] State
);

  state_e state_q;
  state_e state_d;
  ctrl_t  ctrl;

  // State register; reset parks the machine in FETCH on every edge it is held.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_FETCH;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state; Op only matters in DECODE and MEMADR.
  always_comb begin
    state_d = S_FETCH;
    case (state_q)
      S_FETCH:    state_d = S_DECODE;
      S_DECODE: begin
        case (Op)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_RTYPE:     state_d = S_EXECUTE;
          OP_BEQ:       state_d = S_BRANCH;
          OP_ADDI:      state_d = S_ADDIEXEC;
          OP_J:         state_d = S_JUMP;
          default:      state_d = S_FETCH;
        endcase
      end
      S_MEMADR:   state_d = (Op == OP_LW) ? S_MEMREAD : S_MEMWRITE;
      S_MEMREAD:  state_d = S_MEMWB;
      S_EXECUTE:  state_d = S_ALUWB;
      S_ADDIEXEC: state_d = S_ADDIWB;
      default:    state_d = S_FETCH;
    endcase
  end

  mips_ctrl_outdec u_outdec (
    .state (state_q),
    .ctrl  (ctrl)
  );

  // Strobes that change architectural state are suppressed while reset is held.
  always_comb begin
    IorD      = ctrl.iord;
    RegDst    = ctrl.reg_dst;
    MemtoReg  = ctrl.mem_to_reg;
    ALUSrcA   = ctrl.alu_src_a;
    ALUSrcB   = ctrl.alu_src_b;
    ALUOp     = ctrl.alu_op;
    PCSrc     = ctrl.pc_src;
    State     = state_q;
    MemWrite  = ctrl.mem_write & ~reset;
    RegWrite  = ctrl.reg_write & ~reset;
    IRWrite   = ctrl.ir_write & ~reset;
    PCEn      = (ctrl.pc_write | (ctrl.branch & Zero)) & ~reset;
    IllegalOp = (state_q == S_DECODE) & ~is_supported_op(Op) & ~reset;
  end

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Self-checking bench for mips_multicycle_ctrl: directed instruction runs with
// literal expectations, then randomized opcodes/Zero/reset checked every cycle
// against a sequence-list model of each instruction class.
module tb_mips_multicycle_ctrl;

  localparam logic [5:0] LW   = 6'b100011;
  localparam logic [5:0] SW   = 6'b101011;
  localparam logic [5:0] RTY  = 6'b000000;
  localparam logic [5:0] BEQ  = 6'b000100;
  localparam logic [5:0] ADDI = 6'b001000;
  localparam logic [5:0] JMP  = 6'b000010;
  localparam logic [5:0] BAD  = 6'b111111;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [5:0] Op = 6'b0;
  logic       Zero = 1'b0;
  logic       IorD, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite, ALUSrcA;
  logic [1:0] ALUSrcB, ALUOp, PCSrc;
  logic       PCEn, IllegalOp;
  logic [3:0] State;

  int checks = 0;
  int passed = 0;

  mips_multicycle_ctrl dut (
    .clk       (clk),
    .reset     (reset),
    .Op        (Op),
    .Zero      (Zero),
    .IorD      (IorD),
    .MemWrite  (MemWrite),
    .IRWrite   (IRWrite),
    .RegDst    (RegDst),
    .MemtoReg  (MemtoReg),
    .RegWrite  (RegWrite),
    .ALUSrcA   (ALUSrcA),
    .ALUSrcB   (ALUSrcB),
    .ALUOp     (ALUOp),
    .PCSrc     (PCSrc),
    .PCEn      (PCEn),
    .IllegalOp (IllegalOp),
    .State     (State)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual == expected) passed++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
  endtask

  function automatic bit legalOp(input logic [5:0] op);
    return op inside {LW, SW, RTY, BEQ, ADDI, JMP};
  endfunction

  // Expected output word for a state, written straight from the state table.
  function automatic int expOut(input int s, input bit z, input bit rst, input logic [5:0] op);
    bit iord, memw, irw, regdst, m2r, regw, srca, pcen, ill;
    bit [1:0] srcb, aluop, pcsrc;
    {iord, memw, irw, regdst, m2r, regw, srca, pcen, ill} = '0;
    srcb = 2'd0; aluop = 2'd0; pcsrc = 2'd0;
    case (s)
      0:  begin srcb = 2'd1; irw = 1; pcen = 1; end
      1:  begin srcb = 2'd3; ill = !legalOp(op); end
      2:  begin srca = 1; srcb = 2'd2; end
      3:  iord = 1;
      4:  begin m2r = 1; regw = 1; end
      5:  begin iord = 1; memw = 1; end
      6:  begin srca = 1; aluop = 2'd2; end
      7:  begin regdst = 1; regw = 1; end
      8:  begin srca = 1; aluop = 2'd1; pcsrc = 2'd1; pcen = z; end
      9:  begin srca = 1; srcb = 2'd2; end
      10: regw = 1;
      11: begin pcsrc = 2'd2; pcen = 1; end
      default: ;
    endcase
    if (rst) {memw, regw, irw, pcen, ill} = '0;
    return int'({iord, memw, irw, regdst, m2r, regw, srca, srcb, aluop, pcsrc, pcen, ill});
  endfunction

  // Model: each instruction is FETCH, DECODE, then a fixed tail of states per class.
  int  expState = 0;
  int  pend[$];
  bit  modelValid = 1'b0;

  always @(posedge clk) begin
    if (reset) begin
      expState = 0;
      pend.delete();
      modelValid = 1'b1;
    end else if (modelValid) begin
      if (expState == 0) pend.push_back(1);
      else if (expState == 1) begin
        if (Op == LW || Op == SW) pend.push_back(2);
        else if (Op == RTY) begin pend.push_back(6); pend.push_back(7); end
        else if (Op == BEQ) pend.push_back(8);
        else if (Op == ADDI) begin pend.push_back(9); pend.push_back(10); end
        else if (Op == JMP) pend.push_back(11);
      end else if (expState == 2) begin
        if (Op == LW) begin pend.push_back(3); pend.push_back(4); end
        else pend.push_back(5);
      end
      expState = (pend.size() > 0) ? pend.pop_front() : 0;
    end
  end

  // Per-cycle compare plus instruction latency measured on the DUT's State.
  int         latCnt = 0;
  bit         latValid = 1'b0;
  logic [5:0] decOp = 6'b0;
  logic [5:0] memOp = 6'b0;

  function automatic int latency(input logic [5:0] dop, input logic [5:0] mop);
    if (dop == LW || dop == SW) return (mop == LW) ? 5 : 4;
    if (dop == RTY || dop == ADDI) return 4;
    if (dop == BEQ || dop == JMP) return 3;
    return 2;
  endfunction

  always @(negedge clk) begin
    if (modelValid) begin
      checkOutput("state", int'(State), expState);
      checkOutput("outputs",
                  int'({IorD, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite, ALUSrcA,
                        ALUSrcB, ALUOp, PCSrc, PCEn, IllegalOp}),
                  expOut(expState, Zero, reset, Op));
      checkOutput("strobe_onehot", int'((32'(MemWrite) + 32'(RegWrite) + 32'(IRWrite)) <= 1), 1);
      if (reset) latValid = 1'b0;
      else if (State == 4'd0) begin
        if (latValid) checkOutput("latency", latCnt, latency(decOp, memOp));
        latValid = 1'b1;
        latCnt = 1;
      end else begin
        latCnt++;
        if (expState == 1) decOp = Op;
        if (expState == 2) memOp = Op;
      end
    end
  end

  int sState[8];
  bit sAluOp1[8], sAluOp2[8], sRegW[8], sM2R[8], sPcEn[8], sRegDst[8], sIll[8], sMemW[8], sIrw[8];

  // Entered at posedge+1 of a FETCH cycle; records n cycles, leaves at posedge+1.
  task automatic applyStimulus(input logic [5:0] op, input logic z, input int n);
    Op = op;
    Zero = z;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      sState[i]  = int'(State);
      sAluOp1[i] = (ALUOp == 2'b01);
      sAluOp2[i] = (ALUOp == 2'b10);
      sRegW[i]   = RegWrite;
      sM2R[i]    = MemtoReg;
      sPcEn[i]   = PCEn;
      sRegDst[i] = RegDst;
      sIll[i]    = IllegalOp;
      sMemW[i]   = MemWrite;
      sIrw[i]    = IRWrite;
      @(posedge clk);
      #1;
    end
  endtask

  task automatic checkSeq(input string name, input int n, input int exp0, input int exp1,
                          input int exp2, input int exp3, input int exp4);
    int e[5];
    e = '{exp0, exp1, exp2, exp3, exp4};
    for (int i = 0; i < n; i++) checkOutput($sformatf("%s_state%0d", name, i), sState[i], e[i]);
  endtask

  initial begin
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checkOutput("rst_state", int'(State), 0);
      checkOutput("rst_irwrite", int'(IRWrite), 0);
      checkOutput("rst_pcen", int'(PCEn), 0);
    end
    @(posedge clk);
    #1;
    reset = 1'b0;

    applyStimulus(LW, 1'b0, 5);
    checkOutput("post_rst_irwrite", int'(sIrw[0]), 1);
    checkOutput("post_rst_pcen", int'(sPcEn[0]), 1);
    checkSeq("lw", 5, 0, 1, 2, 3, 4);
    for (int i = 0; i < 5; i++) begin
      checkOutput("lw_regwrite", int'(sRegW[i]), int'(i == 4));
      checkOutput("lw_memtoreg", int'(sM2R[i]), int'(i == 4));
    end

    applyStimulus(BEQ, 1'b1, 3);
    checkSeq("beq_z1", 3, 0, 1, 8, 0, 0);
    checkOutput("beq_z1_pcen_decode", int'(sPcEn[1]), 0);
    checkOutput("beq_z1_pcen", int'(sPcEn[2]), 1);
    checkOutput("beq_aluop_sub", int'(sAluOp1[2]), 1);

    applyStimulus(BEQ, 1'b0, 3);
    checkSeq("beq_z0", 3, 0, 1, 8, 0, 0);
    checkOutput("beq_z0_pcen", int'(sPcEn[2]), 0);

    applyStimulus(RTY, 1'b0, 4);
    checkSeq("rtype", 4, 0, 1, 6, 7, 0);
    for (int i = 0; i < 4; i++) checkOutput("rtype_aluop_funct", int'(sAluOp2[i]), int'(i == 2));
    checkOutput("rtype_regdst", int'(sRegDst[3]), 1);

    applyStimulus(BAD, 1'b0, 2);
    checkSeq("illegal", 2, 0, 1, 0, 0, 0);
    for (int i = 0; i < 2; i++) begin
      checkOutput("illegal_pulse", int'(sIll[i]), int'(i == 1));
      checkOutput("illegal_nowrite", int'(sMemW[i] | sRegW[i]), 0);
    end

    applyStimulus(ADDI, 1'b0, 4);
    checkSeq("addi", 4, 0, 1, 9, 10, 0);
    checkOutput("addi_regwrite", int'(sRegW[3]), 1);

    applyStimulus(SW, 1'b0, 2);
    checkSeq("sw", 2, 0, 1, 0, 0, 0);
    reset = 1'b1;
    @(negedge clk);
    checkOutput("sw_rst_state", int'(State), 2);
    checkOutput("sw_rst_memwrite", int'(MemWrite), 0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    applyStimulus(JMP, 1'b0, 3);
    checkSeq("after_abort", 3, 0, 1, 11, 0, 0);
    for (int i = 0; i < 3; i++) checkOutput("after_abort_memwrite", int'(sMemW[i]), 0);
    checkOutput("jump_pcen", int'(sPcEn[2]), 1);

    // Random phase: Op and Zero change every cycle, occasional reset pulses.
    for (int c = 0; c < 3000; c++) begin
      automatic logic [5:0] ops[6] = '{LW, SW, RTY, BEQ, ADDI, JMP};
      if ($urandom_range(0, 9) < 7) Op = ops[$urandom_range(0, 5)];
      else Op = 6'($urandom);
      Zero = 1'($urandom);
      reset = ($urandom_range(0, 39) == 0);
      @(posedge clk);
      #1;
    end
    reset = 1'b0;
    @(negedge clk);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
